// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared types and helpers for the 8x8 dot-matrix scan controller.
//   ROWS / COLS   : image geometry
//   row_idx_t     : 3-bit row index
//   row_bits_t    : 8-bit row pattern, bit 7 = leftmost column
//   scan_state_t  : scan FSM states (BLANK only reachable with MATRIX_BLANK_EN)
//   row_sel()     : active-low row select for a given row index
// -----------------------------------------------------------------------------
package matrix_pkg;

   localparam int ROWS = 8;
   localparam int COLS = 8;

   typedef logic [2:0]      row_idx_t;
   typedef logic [COLS-1:0] row_bits_t;

   typedef enum logic {
      SCAN  = 1'b0,
      BLANK = 1'b1
   } scan_state_t;

   // Row r pulls bit (7-r) low; every other row line stays high.
   function automatic row_bits_t row_sel(input row_idx_t r);
      return ~(8'h80 >> r);
   endfunction

endpackage

// File: rtl/matrix_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// matrix_scan_ctrl_if
// Write-request bundle for the two image requesters (keypad decoder and
// animation engine).
//   reqN_valid  requester N has a row write pending
//   reqN_ready  requester N is granted this cycle (combinational from the DUT)
//   reqN_row    target row index 0..7
//   reqN_data   row pattern, bit 7 = leftmost column
// Modports: master = requester side, slave = matrix_scan_ctrl side.
// -----------------------------------------------------------------------------
interface matrix_scan_ctrl_if;
   import matrix_pkg::*;

   logic      req0_valid;
   logic      req0_ready;
   row_idx_t  req0_row;
   row_bits_t req0_data;
   logic      req1_valid;
   logic      req1_ready;
   row_idx_t  req1_row;
   row_bits_t req1_data;

   modport master (
      output req0_valid, req0_row, req0_data,
      output req1_valid, req1_row, req1_data,
      input  req0_ready, req1_ready
   );

   modport slave (
      input  req0_valid, req0_row, req0_data,
      input  req1_valid, req1_row, req1_data,
      output req0_ready, req1_ready
   );

endinterface

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter for image writes.
//   clk_i, rst_i        clock, asynchronous active-high reset
//   valid0_i, valid1_i  request lines
//   hold_i              suppresses both grants (image clear in progress)
//   grant0_o, grant1_o  combinational grants, at most one high
// The turn pointer only moves on a contended grant; an uncontested
// requester is simply served and leaves the turn where it was.
// -----------------------------------------------------------------------------
module rr_arbiter2 (
   input  logic clk_i,
   input  logic rst_i,
   input  logic valid0_i,
   input  logic valid1_i,
   input  logic hold_i,
   output logic grant0_o,
   output logic grant1_o
);

   logic ptr_q;   // 0: requester 0 owns the turn, 1: requester 1
   logic ptr_d;

   // Grant decode and turn-pointer update
   always_comb begin
      grant0_o = 1'b0;
      grant1_o = 1'b0;
      ptr_d    = ptr_q;
      if (hold_i) begin
         ptr_d = ptr_q;
      end else if (valid0_i && valid1_i) begin
         if (ptr_q == 1'b0) begin
            grant0_o = 1'b1;
         end else begin
            grant1_o = 1'b1;
         end
         ptr_d = ~ptr_q;
      end else begin
         grant0_o = valid0_i;
         grant1_o = valid1_i;
      end
   end

   // Turn-pointer register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/matrix_scan_ctrl.sv
// -----------------------------------------------------------------------------
// matrix_scan_ctrl
// Row-scan controller and shared 8x8 frame buffer for the dot-matrix display.
// Parameters:
//   DWELL  cycles each row is driven (>=1)
//   BLANK  blank cycles between rows (>=1), used only with MATRIX_BLANK_EN
// Ports:
//   ani_clk      scan/system clock
//   reset        asynchronous active-high reset
//   wr_if        two-requester write bundle (slave side), round-robin arbitrated
//   clear        synchronous clear of the whole image, overrides writes
//   dot_row      active-low row select (registered)
//   dot_col      active-high column data (registered)
//   frame_start  one-cycle pulse on the first cycle row 0 is driven
// Build option: define MATRIX_BLANK_EN to insert BLANK all-off cycles after
// every row's dwell (anti-ghosting). Without it rows are back-to-back.
// -----------------------------------------------------------------------------
module matrix_scan_ctrl
   import matrix_pkg::*;
#(
   parameter int DWELL = 4,
   parameter int BLANK = 1
) (
   input  logic                  ani_clk,
   input  logic                  reset,
   matrix_scan_ctrl_if.slave     wr_if,
   input  logic                  clear,
   output logic [7:0]            dot_row,
   output logic [7:0]            dot_col,
   output logic                  frame_start
);

   localparam int DW = $clog2(DWELL + 1);

   if (DWELL < 1 || BLANK < 1) begin : g_bad_param
      $error("matrix_scan_ctrl: DWELL and BLANK must both be >= 1");
   end

   logic        grant0;
   logic        grant1;
   row_bits_t   image_q [ROWS];

   scan_state_t state_q,   state_d;
   row_idx_t    row_q,     row_d;
   row_idx_t    row_nxt;
   logic [DW-1:0] dwell_q, dwell_d;     // cycles the current row has been driven; 0 = not yet entered
   row_bits_t   dot_row_q, dot_row_d;
   row_bits_t   dot_col_q, dot_col_d;
   logic        fs_q,      fs_d;

`ifdef MATRIX_BLANK_EN
   localparam int BW = $clog2(BLANK + 1);
   logic [BW-1:0] blank_q, blank_d;
`endif

   rr_arbiter2 u_arb (
      .clk_i    (ani_clk),
      .rst_i    (reset),
      .valid0_i (wr_if.req0_valid),
      .valid1_i (wr_if.req1_valid),
      .hold_i   (clear),
      .grant0_o (grant0),
      .grant1_o (grant1)
   );

   assign wr_if.req0_ready = grant0;
   assign wr_if.req1_ready = grant1;

   assign row_nxt = row_q + 3'd1;   // 7 wraps to 0

   // Frame buffer: clear wins, otherwise at most one granted row write
   always_ff @(posedge ani_clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ROWS; i++) begin
            image_q[i] <= 8'h00;
         end
      end else if (clear) begin
         for (int i = 0; i < ROWS; i++) begin
            image_q[i] <= 8'h00;
         end
      end else if (grant0) begin
         image_q[wr_if.req0_row] <= wr_if.req0_data;
      end else if (grant1) begin
         image_q[wr_if.req1_row] <= wr_if.req1_data;
      end
   end

   // Scan sequencing: dwell count, row advance/wrap, optional blanking, output staging.
   // Row data is captured only on row entry, so writes to the live row wait for its next visit.
   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      dwell_d   = dwell_q;
      dot_row_d = dot_row_q;
      dot_col_d = dot_col_q;
      fs_d      = 1'b0;
`ifdef MATRIX_BLANK_EN
      blank_d   = blank_q;
`endif
      case (state_q)
         matrix_pkg::SCAN: begin
            if (dwell_q == DW'(0)) begin
               // first edge after reset: enter the current row
               dot_row_d = row_sel(row_q);
               dot_col_d = image_q[row_q];
               fs_d      = (row_q == 3'd0);
               dwell_d   = DW'(1);
            end else if (dwell_q == DW'(DWELL)) begin
`ifdef MATRIX_BLANK_EN
               state_d   = matrix_pkg::BLANK;
               row_d     = row_nxt;
               dot_row_d = 8'hFF;
               dot_col_d = 8'h00;
               blank_d   = BW'(1);
`else
               row_d     = row_nxt;
               dot_row_d = row_sel(row_nxt);
               dot_col_d = image_q[row_nxt];
               fs_d      = (row_nxt == 3'd0);
               dwell_d   = DW'(1);
`endif
            end else begin
               dwell_d = dwell_q + DW'(1);
            end
         end
`ifdef MATRIX_BLANK_EN
         matrix_pkg::BLANK: begin
            // row_q already points at the row to enter
            if (blank_q == BW'(BLANK)) begin
               state_d   = matrix_pkg::SCAN;
               dot_row_d = row_sel(row_q);
               dot_col_d = image_q[row_q];
               fs_d      = (row_q == 3'd0);
               dwell_d   = DW'(1);
            end else begin
               blank_d = blank_q + BW'(1);
            end
         end
`endif
         default: begin
            state_d   = matrix_pkg::SCAN;
            row_d     = 3'd0;
            dwell_d   = DW'(0);
            dot_row_d = 8'hFF;
            dot_col_d = 8'h00;
         end
      endcase
   end

   // Scan state and registered display outputs
   always_ff @(posedge ani_clk or posedge reset) begin
      if (reset) begin
         state_q   <= matrix_pkg::SCAN;
         row_q     <= 3'd0;
         dwell_q   <= DW'(0);
         dot_row_q <= 8'hFF;
         dot_col_q <= 8'h00;
         fs_q      <= 1'b0;
`ifdef MATRIX_BLANK_EN
         blank_q   <= BW'(0);
`endif
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         dwell_q   <= dwell_d;
         dot_row_q <= dot_row_d;
         dot_col_q <= dot_col_d;
         fs_q      <= fs_d;
`ifdef MATRIX_BLANK_EN
         blank_q   <= blank_d;
`endif
      end
   end

   assign dot_row     = dot_row_q;
   assign dot_col     = dot_col_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_matrix_scan_ctrl
// Directed bench for matrix_scan_ctrl at DWELL=4, BLANK=1. Expected values
// are hand-derived; blanking-dependent expectations follow MATRIX_BLANK_EN.
// -----------------------------------------------------------------------------
module tb_matrix_scan_ctrl;

   localparam int DWELL = 4;
   localparam int BLANK = 1;
`ifdef MATRIX_BLANK_EN
   localparam int       PERIOD   = 8 * (DWELL + BLANK);
   localparam bit       BLANKING = 1'b1;
`else
   localparam int       PERIOD   = 8 * DWELL;
   localparam bit       BLANKING = 1'b0;
`endif

   logic       ani_clk;
   logic       reset;
   logic       clear;
   logic [7:0] dot_row;
   logic [7:0] dot_col;
   logic       frame_start;

   int n_checks;
   int n_fail;

   matrix_scan_ctrl_if wr_if ();

   matrix_scan_ctrl #(.DWELL(DWELL), .BLANK(BLANK)) dut (
      .ani_clk     (ani_clk),
      .reset       (reset),
      .wr_if       (wr_if),
      .clear       (clear),
      .dot_row     (dot_row),
      .dot_col     (dot_col),
      .frame_start (frame_start)
   );

   initial ani_clk = 1'b0;
   always #5 ani_clk = ~ani_clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h", tag, act, exp);
      end
   endtask

   // one clock: step past the rising edge so registered outputs are settled
   task automatic tick();
      @(posedge ani_clk);
      #1;
   endtask

   task automatic wait_row(input logic [7:0] sel, input string tag);
      int n = 0;
      while (dot_row !== sel && n < 200) begin
         tick();
         n++;
      end
      check_eq(tag, dot_row, sel);
   endtask

   task automatic wait_frame(input string tag);
      int n = 0;
      while (frame_start !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      check_eq(tag, frame_start, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int          per;
      logic [7:0]  prev_row;

      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      clear    = 1'b0;
      wr_if.req0_valid = 1'b0; wr_if.req0_row = 3'd0; wr_if.req0_data = 8'h00;
      wr_if.req1_valid = 1'b0; wr_if.req1_row = 3'd0; wr_if.req1_data = 8'h00;

      // reset state
      tick();
      check_eq("rst_row", dot_row, 8'hFF);
      check_eq("rst_col", dot_col, 8'h00);
      check_eq("rst_fs", frame_start, 1'b0);
      check_eq("idle_rdy0", wr_if.req0_ready, 1'b0);
      check_eq("idle_rdy1", wr_if.req1_ready, 1'b0);
      reset = 1'b0;
      tick();
      check_eq("rel_fs", frame_start, 1'b1);
      check_eq("rel_row0", dot_row, 8'h7F);
      check_eq("rel_col0", dot_col, 8'h00);
      tick();
      check_eq("fs_pulse", frame_start, 1'b0);

      // single write from requester 0
      wr_if.req0_valid = 1'b1; wr_if.req0_row = 3'd2; wr_if.req0_data = 8'hC3;
      #1;
      check_eq("w0_rdy0", wr_if.req0_ready, 1'b1);
      check_eq("w0_rdy1", wr_if.req1_ready, 1'b0);
      tick();
      wr_if.req0_valid = 1'b0;
      wait_row(8'hDF, "row2_reach");
      check_eq("row2_col_c1", dot_col, 8'hC3);
      // write the live row: must not appear until the next visit
      wr_if.req1_valid = 1'b1; wr_if.req1_row = 3'd2; wr_if.req1_data = 8'h5A;
      #1;
      check_eq("w1_rdy1", wr_if.req1_ready, 1'b1);
      check_eq("w1_rdy0", wr_if.req0_ready, 1'b0);
      tick();
      wr_if.req1_valid = 1'b0;
      for (int i = 2; i <= DWELL; i++) begin
         check_eq("row2_hold_row", dot_row, 8'hDF);
         check_eq("row2_hold_col", dot_col, 8'hC3);
         tick();
      end
      check_eq("after_row2_row", dot_row, BLANKING ? 8'hFF : 8'hEF);
      check_eq("after_row2_col", dot_col, 8'h00);
      wait_frame("frame_a");
      wait_row(8'hDF, "row2_revisit");
      check_eq("row2_new_col", dot_col, 8'h5A);

      // contention: grants alternate 0,1,0,1
      for (int k = 0; k < 4; k++) begin
         wr_if.req0_valid = 1'b1; wr_if.req0_row = 3'd1; wr_if.req0_data = 8'h10 + 8'(k);
         wr_if.req1_valid = 1'b1; wr_if.req1_row = 3'd5; wr_if.req1_data = 8'h50 + 8'(k);
         #1;
         check_eq("rr_rdy0", wr_if.req0_ready, (k % 2 == 0) ? 1'b1 : 1'b0);
         check_eq("rr_rdy1", wr_if.req1_ready, (k % 2 == 1) ? 1'b1 : 1'b0);
         tick();
      end
      wr_if.req0_valid = 1'b0;
      wr_if.req1_valid = 1'b0;
      wait_frame("frame_b");
      wait_row(8'hBF, "row1_reach");
      check_eq("row1_col", dot_col, 8'h12);
      wait_row(8'hFB, "row5_reach");
      check_eq("row5_col", dot_col, 8'h53);

      // clear with both requesters valid
      wr_if.req0_valid = 1'b1; wr_if.req0_row = 3'd3; wr_if.req0_data = 8'hFF;
      wr_if.req1_valid = 1'b1; wr_if.req1_row = 3'd4; wr_if.req1_data = 8'hFF;
      clear = 1'b1;
      #1;
      check_eq("clr_rdy0", wr_if.req0_ready, 1'b0);
      check_eq("clr_rdy1", wr_if.req1_ready, 1'b0);
      tick();
      clear = 1'b0;
      wr_if.req0_valid = 1'b0;
      wr_if.req1_valid = 1'b0;
      wait_frame("frame_c");
      for (int i = 0; i < PERIOD; i++) begin
         check_eq("clr_col", dot_col, 8'h00);
         tick();
      end

      // frame period, wrap from row 7 and single-cycle frame_start
      wait_frame("frame_d");
      per      = 0;
      prev_row = dot_row;
      do begin
         prev_row = dot_row;
         tick();
         per++;
      end while (frame_start !== 1'b1 && per < 200);
      check_eq("frame_period", per, PERIOD);
      check_eq("wrap_prev_row", prev_row, BLANKING ? 8'hFF : 8'hFE);
      check_eq("wrap_row0", dot_row, 8'h7F);
      tick();
      check_eq("wrap_fs_clr", frame_start, 1'b0);
      check_eq("wrap_row0_hold", dot_row, 8'h7F);

      // asynchronous reset mid-row
      wait_row(8'hEF, "row3_reach");
      tick();
      #2;
      reset = 1'b1;
      #1;
      check_eq("mid_rst_row", dot_row, 8'hFF);
      check_eq("mid_rst_col", dot_col, 8'h00);
      check_eq("mid_rst_fs", frame_start, 1'b0);
      #1;
      reset = 1'b0;
      tick();
      check_eq("rel2_fs", frame_start, 1'b1);
      check_eq("rel2_row0", dot_row, 8'h7F);
      for (int i = 2; i <= DWELL; i++) begin
         tick();
         check_eq("rel2_row0_dwell", dot_row, 8'h7F);
      end
      tick();
      check_eq("rel2_next", dot_row, BLANKING ? 8'hFF : 8'hBF);
      wait_row(8'hDF, "row2_after_rst");
      check_eq("image_lost", dot_col, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
